// File: rtl/imm_pkg.sv
// Shared constants for the registered RISC-V immediate generator: opcodes,
// shift funct3 codes, format encodings, occupancy states and the XLEN check.
package imm_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ILL   = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    CNT_EMPTY   = 2'd0,
    CNT_PARTIAL = 2'd1,
    CNT_FULL    = 2'd2
  } cnt_state_e;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

  function automatic bit depth_legal(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate/format decoder for one 32-bit RISC-V instruction.
// Every format is first assembled as a sign-correct 32-bit value, then widened.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt
);

  localparam int SH_W = (XLEN == 64) ? 6 : 5;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] raw;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  always_comb begin
    raw = '0;
    fmt = FMT_ILL;
    case (opcode)
      OPC_LOAD, OPC_JALR: begin
        raw = {{20{inst[31]}}, inst[31:20]};
        fmt = FMT_I;
      end
      OPC_OP_IMM: begin
        if (funct3 == F3_SLL || funct3 == F3_SRX) begin
          // bit 31 of raw stays clear, so the widening below zero-extends
          raw = 32'(inst[20 +: SH_W]);
          fmt = FMT_SHAMT;
        end else begin
          raw = {{20{inst[31]}}, inst[31:20]};
          fmt = FMT_I;
        end
      end
      OPC_STORE: begin
        raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        fmt = FMT_S;
      end
      OPC_BRANCH: begin
        raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        fmt = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        raw = {inst[31:12], 12'b0};
        fmt = FMT_U;
      end
      OPC_JAL: begin
        raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        fmt = FMT_J;
      end
      OPC_OP: begin
        raw = '0;
        fmt = FMT_NONE;
      end
      default: begin
        raw = '0;
        fmt = FMT_ILL;
      end
    endcase
  end

  assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decode on push, DEPTH-entry in-order result FIFO.
// Optional macro IMM_GEN_ILL_CHECK_EN adds a stored illegal-opcode flag driving ill_out.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [2:0]       fmt_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             ill_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("imm_gen_pipe: DEPTH must be a power of two and at least 2");
  end

  logic [XLEN-1:0]  ext_imm;
  fmt_e             ext_fmt;

  logic [XLEN-1:0]  imm_mem [DEPTH];
  fmt_e             fmt_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] head_idx;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  cnt_state_e       state_reg;
  cnt_state_e       state_next;

  logic             push;
  logic             pop;
  logic [DEPTH-1:0] wr_en;

  imm_extract #(
    .XLEN(XLEN)
  ) u_extract (
    .inst(in_inst),
    .imm (ext_imm),
    .fmt (ext_fmt)
  );

  assign out_valid = (state_reg != CNT_EMPTY);
  assign pop       = out_valid && out_ready;
  assign in_ready  = (state_reg != CNT_FULL) || pop;
  assign push      = in_valid && in_ready;

  // When empty, the slot just behind rd_ptr still holds the last popped entry.
  assign head_idx = (state_reg == CNT_EMPTY) ? (rd_ptr_reg - PTR_W'(1)) : rd_ptr_reg;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = push && (wr_ptr_reg == PTR_W'(gi));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        imm_mem[i] <= '0;
        fmt_mem[i] <= FMT_NONE;
        tag_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          imm_mem[i] <= ext_imm;
          fmt_mem[i] <= ext_fmt;
          tag_mem[i] <= in_tag;
        end
      end
    end
  end

  assign imm_out = imm_mem[head_idx];
  assign fmt_out = fmt_mem[head_idx];
  assign tag_out = tag_mem[head_idx];

`ifdef IMM_GEN_ILL_CHECK_EN
  logic ill_mem [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ill_mem[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          ill_mem[i] <= (ext_fmt == FMT_ILL);
        end
      end
    end
  end

  assign ill_out = ill_mem[head_idx];
`else
  assign ill_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= CNT_EMPTY;
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      CNT_EMPTY: begin
        if (push) begin
          count_next = CNT_W'(1);
          state_next = CNT_PARTIAL;
        end
      end
      CNT_PARTIAL: begin
        if (push && !pop) begin
          count_next = count_reg + CNT_W'(1);
          state_next = (count_reg == CNT_W'(DEPTH - 1)) ? CNT_FULL : CNT_PARTIAL;
        end else if (pop && !push) begin
          count_next = count_reg - CNT_W'(1);
          state_next = (count_reg == CNT_W'(1)) ? CNT_EMPTY : CNT_PARTIAL;
        end
      end
      CNT_FULL: begin
        // push with pop keeps the buffer full; pop alone drops to partial
        if (pop && !push) begin
          count_next = count_reg - CNT_W'(1);
          state_next = CNT_PARTIAL;
        end
      end
      default: begin
        state_next = CNT_EMPTY;
        count_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share inputs and are
// checked against a queue-based reference model plus directed known values.
module tb_imm_gen_pipe;

  localparam int DEPTH = 2;
`ifdef IMM_GEN_ILL_CHECK_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [3:0]  in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [3:0]  tag32;
  logic        in_ready64, out_valid64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [3:0]  tag64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(4)) dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready32),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
    .imm_out(imm32), .fmt_out(fmt32), .tag_out(tag32), .ill_out(ill32)
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(4)) dut64 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .imm_out(imm64), .fmt_out(fmt64), .tag_out(tag64), .ill_out(ill64)
  );

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  tag;
  } ent_t;

  ent_t        q[$];
  logic [3:0]  popped_tags[$];
  int          chk_cnt = 0;
  int          err_cnt = 0;
  logic [63:0] last_i32, last_i64;
  logic [2:0]  last_f32, last_f64;
  logic [3:0]  last_tag;
  bit          last_v, last_ir;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference decode with whole-word arithmetic shifts on a sign-extended copy.
  function automatic void ref_decode(input logic [31:0] inst, input bit is64,
                                     output logic [63:0] imm, output logic [2:0] fmt);
    longint s, a;
    s = longint'($signed(inst));
    imm = 64'd0;
    fmt = 3'd7;
    case (inst[6:0])
      7'h03, 7'h67: begin a = s >>> 20; imm = a; fmt = 3'd1; end
      7'h13: begin
        if (inst[14:12] == 3'b001 || inst[14:12] == 3'b101) begin
          imm = is64 ? 64'(inst[25:20]) : 64'(inst[24:20]);
          fmt = 3'd6;
        end else begin
          a = s >>> 20; imm = a; fmt = 3'd1;
        end
      end
      7'h23: begin a = s >>> 25; a = a <<< 5; imm = a | longint'(inst[11:7]); fmt = 3'd2; end
      7'h63: begin
        a = s >>> 31; a = a <<< 12;
        a = a | (longint'(inst[7]) <<< 11) | (longint'(inst[30:25]) <<< 5) | (longint'(inst[11:8]) <<< 1);
        imm = a; fmt = 3'd3;
      end
      7'h37, 7'h17: begin a = s & -64'sd4096; imm = a; fmt = 3'd4; end
      7'h6F: begin
        a = s >>> 31; a = a <<< 20;
        a = a | (longint'(inst[19:12]) <<< 12) | (longint'(inst[20]) <<< 11) | (longint'(inst[30:21]) <<< 1);
        imm = a; fmt = 3'd5;
      end
      7'h33: begin imm = 64'd0; fmt = 3'd0; end
      default: begin imm = 64'd0; fmt = 3'd7; end
    endcase
    if (!is64) imm = imm & 64'h0000_0000_FFFF_FFFF;
  endfunction

  task automatic model_reset();
    q.delete();
    last_i32 = '0; last_i64 = '0; last_f32 = '0; last_f64 = '0; last_tag = '0;
    last_v = 1'b0; last_ir = 1'b1;
  endtask

  // One clock of stimulus; outputs are checked between edges against the model.
  task automatic cycle(input bit v, input logic [31:0] inst, input logic [3:0] tag, input bit ordy);
    logic [63:0] i32, i64;
    logic [2:0]  f32, f64;
    logic [3:0]  t;
    bit          ov, pp, ir;
    ent_t        e;
    @(negedge clk);
    in_valid = v; in_inst = inst; in_tag = tag; out_ready = ordy;
    #1;
    ov = (q.size() != 0);
    pp = ov && ordy;
    ir = (q.size() != DEPTH) || pp;
    check("out_valid32", 64'(out_valid32), 64'(ov));
    check("out_valid64", 64'(out_valid64), 64'(ov));
    check("in_ready32", 64'(in_ready32), 64'(ir));
    check("in_ready64", 64'(in_ready64), 64'(ir));
    if (ov) begin
      e = q[0];
      ref_decode(e.inst, 1'b0, i32, f32);
      ref_decode(e.inst, 1'b1, i64, f64);
      t = e.tag;
    end else begin
      i32 = last_i32; i64 = last_i64; f32 = last_f32; f64 = last_f64; t = last_tag;
    end
    check("imm32", 64'(imm32), i32);
    check("imm64", imm64, i64);
    check("fmt32", 64'(fmt32), 64'(f32));
    check("fmt64", 64'(fmt64), 64'(f64));
    check("tag32", 64'(tag32), 64'(t));
    check("tag64", 64'(tag64), 64'(t));
    check("ill32", 64'(ill32), 64'(ILL_EN && (f32 == 3'd7)));
    check("ill64", 64'(ill64), 64'(ILL_EN && (f64 == 3'd7)));
    if (pp) begin
      last_i32 = i32; last_i64 = i64; last_f32 = f32; last_f64 = f64; last_tag = t;
      void'(q.pop_front());
      popped_tags.push_back(t);
    end
    if (v && ir) q.push_back('{inst, tag});
    last_v = v;
    last_ir = ir;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 10))
      0: r[6:0] = 7'h03;
      1: r[6:0] = 7'h13;
      2: r[6:0] = 7'h67;
      3: r[6:0] = 7'h23;
      4: r[6:0] = 7'h63;
      5: r[6:0] = 7'h37;
      6: r[6:0] = 7'h17;
      7: r[6:0] = 7'h6F;
      8: r[6:0] = 7'h33;
      9: r[6:0] = 7'h13;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    logic [31:0] ri;
    logic [3:0]  rt;
    bit          rv;
    int          next_tag;

    reset_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_tag = '0; out_ready = 1'b0;
    model_reset();
    #2;
    check("rst_out_valid", 64'(out_valid32), 64'd0);
    check("rst_in_ready", 64'(in_ready32), 64'd1);
    check("rst_imm64", imm64, 64'd0);
    check("rst_fmt", 64'(fmt32), 64'd0);
    check("rst_tag", 64'(tag32), 64'd0);
    check("rst_ill", 64'(ill64), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // addi x1,x0,-1
    cycle(1'b1, 32'hFFF0_0093, 4'd1, 1'b1);
    cycle(1'b0, 32'h0, 4'd0, 1'b1);
    check("addi_imm", 64'(imm32), 64'hFFFF_FFFF);
    check("addi_fmt", 64'(fmt32), 64'd1);
    // srai then beq -4
    cycle(1'b1, 32'h41F0_D093, 4'd2, 1'b1);
    cycle(1'b1, 32'hFE00_0EE3, 4'd3, 1'b1);
    check("srai_imm", 64'(imm32), 64'h1F);
    check("srai_fmt", 64'(fmt32), 64'd6);
    cycle(1'b0, 32'h0, 4'd0, 1'b1);
    check("beq_imm32", 64'(imm32), 64'hFFFF_FFFC);
    check("beq_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
    check("beq_fmt", 64'(fmt32), 64'd3);
    // lui, positive and negative upper immediate
    cycle(1'b1, 32'h1234_52B7, 4'd4, 1'b1);
    cycle(1'b1, 32'h8000_02B7, 4'd5, 1'b1);
    check("lui_imm64", imm64, 64'h0000_0000_1234_5000);
    check("lui_fmt", 64'(fmt64), 64'd4);
    cycle(1'b0, 32'h0, 4'd0, 1'b1);
    check("lui_neg_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
    check("lui_neg_imm32", 64'(imm32), 64'h8000_0000);
    // unknown opcode
    cycle(1'b1, 32'h0000_007F, 4'd6, 1'b1);
    cycle(1'b0, 32'h0, 4'd0, 1'b1);
    check("ill_fmt", 64'(fmt32), 64'd7);
    check("ill_imm", imm64, 64'd0);
    check("ill_flag", 64'(ill32), 64'(ILL_EN));
    cycle(1'b0, 32'h0, 4'd0, 1'b0);
    check("hold_fmt", 64'(fmt32), 64'd7);

    // back-pressure, push+pop while full, in-order drain of tags 0..5
    popped_tags.delete();
    next_tag = 0;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 32'h0000_0093 | (32'(next_tag) << 20), 4'(next_tag), 1'b0);
      if (last_ir) next_tag++;
    end
    check("bp_in_ready", 64'(in_ready32), 64'd0);
    check("bp_pushes", 64'(next_tag), 64'(DEPTH));
    cycle(1'b1, 32'h0000_0093 | (32'(next_tag) << 20), 4'(next_tag), 1'b1);
    check("full_pushpop_ready", 64'(in_ready32), 64'd1);
    if (last_ir) next_tag++;
    for (int k = 0; k < 30 && popped_tags.size() < 6; k++) begin
      rv = (next_tag < 6);
      cycle(rv, 32'h0000_0093 | (32'(next_tag) << 20), 4'(next_tag), 1'b1);
      if (rv && last_ir) next_tag++;
    end
    check("bp_pop_count", 64'(popped_tags.size()), 64'd6);
    for (int k = 0; k < 6 && k < popped_tags.size(); k++) begin
      check("bp_order", 64'(popped_tags[k]), 64'(k));
    end

    // asynchronous reset with two entries buffered
    cycle(1'b1, 32'h0010_0093, 4'd9, 1'b0);
    cycle(1'b1, 32'h0020_0093, 4'd10, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid32), 64'd0);
    check("arst_in_ready", 64'(in_ready64), 64'd1);
    check("arst_imm", imm64, 64'd0);
    check("arst_tag", 64'(tag32), 64'd0);
    #2;
    reset_n = 1'b1;
    model_reset();
    cycle(1'b0, 32'h0, 4'd0, 1'b1);
    cycle(1'b0, 32'h0, 4'd0, 1'b1);

    // randomized traffic, holding inputs while stalled
    ri = '0; rt = '0; rv = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!(last_v && !last_ir)) begin
        rv = ($urandom_range(0, 9) < 7);
        ri = rand_inst();
        rt = 4'($urandom());
      end
      cycle(rv, ri, rt, ($urandom_range(0, 9) < 6));
    end
    for (int k = 0; k < DEPTH + 2; k++) begin
      cycle(1'b0, 32'h0, 4'd0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
